// File: rtl/iobus_router.sv
// iobus_router: address-window decoder, response mux and default responder
// for the MicroBlaze MCS IO bus. Tracks the single outstanding transaction.
// Optional watchdog enabled by defining IOBUS_ROUTER_TIMEOUT_EN; without it,
// BUSY waits indefinitely for the selected slot and err_timeout is tied to 0.
module iobus_router #(
  parameter logic [31:0] BASE_ADDRESS   = 32'hC0000000,
  parameter logic [31:0] ADDRESS_STRIDE = 32'h1000,
  parameter int          SLOT_COUNT     = 4,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input  logic                     io_clk,
  input  logic                     io_rst,
  input  logic                     io_addr_strobe,
  input  logic [31:0]              io_address,
  output logic [31:0]              io_read_data,
  output logic                     io_ready,
  output logic [SLOT_COUNT-1:0]    s_addr_strobe,
  input  logic [32*SLOT_COUNT-1:0] s_read_data,
  input  logic [SLOT_COUNT-1:0]    s_ready,
  input  logic                     err_clear,
  output logic                     err_irq,
  output logic                     err_unmapped,
  output logic                     err_timeout,
  output logic [31:0]              err_addr
);

  localparam int          STRIDE_LG = $clog2(ADDRESS_STRIDE);
  localparam int          SEL_W     = (SLOT_COUNT > 1) ? $clog2(SLOT_COUNT) : 1;
  localparam logic [32:0] WINDOW    = 33'(SLOT_COUNT) * {1'b0, ADDRESS_STRIDE};

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_ERR  = 2'b10;

  logic [1:0]       state;
  logic [SEL_W-1:0] sel;
  logic [31:0]      offset;
  logic             hit;
  logic [SEL_W-1:0] slot_idx;
  logic             sel_ready;
  logic [31:0]      sel_data;
  logic             expire;
  logic [31:0]      expire_addr;

  // The subtraction wraps for addresses below the base, so the lower bound
  // is checked separately; the window compare is 33 bits so a window that
  // ends exactly at 4 GiB does not overflow.
  assign offset    = io_address - BASE_ADDRESS;
  assign hit       = (io_address >= BASE_ADDRESS) && ({1'b0, offset} < WINDOW);
  assign slot_idx  = SEL_W'(offset >> STRIDE_LG);
  assign sel_ready = s_ready[sel];
  assign sel_data  = s_read_data[32*int'(sel) +: 32];

  // Upstream response and slot strobe; strobes are suppressed during reset
  // so that reset silences every output immediately.
  always_comb begin
    s_addr_strobe = '0;
    io_ready      = 1'b0;
    io_read_data  = '0;
    err_irq       = 1'b0;
    if (state == ST_IDLE && io_addr_strobe && hit && !io_rst)
      s_addr_strobe = SLOT_COUNT'(1) << slot_idx;
    if (state == ST_BUSY && sel_ready) begin
      io_ready     = 1'b1;
      io_read_data = sel_data;
    end else if (state == ST_ERR) begin
      io_ready     = 1'b1;
      io_read_data = ERR_DATA;
      err_irq      = 1'b1;
    end
  end

  // Transaction FSM plus sticky unmapped flag and failing-address capture;
  // an error raised in the same cycle as err_clear overrides the clear.
  always_ff @(posedge io_clk or posedge io_rst) begin
    if (io_rst) begin
      state        <= ST_IDLE;
      sel          <= '0;
      err_unmapped <= 1'b0;
      err_addr     <= '0;
    end else begin
      if (err_clear) begin
        err_unmapped <= 1'b0;
        err_addr     <= '0;
      end
      case (state)
        ST_IDLE: begin
          if (io_addr_strobe) begin
            if (hit) begin
              sel   <= slot_idx;
              state <= ST_BUSY;
            end else begin
              state        <= ST_ERR;
              err_unmapped <= 1'b1;
              err_addr     <= io_address;
            end
          end
        end
        ST_BUSY: begin
          if (sel_ready) begin
            state <= ST_IDLE;
          end else if (expire) begin
            state    <= ST_ERR;
            err_addr <= expire_addr;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef IOBUS_ROUTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic [31:0]      txn_addr;

  // Expiry fires on the last permitted stall cycle; a ready in that same
  // cycle takes priority in the FSM.
  assign expire      = (state == ST_BUSY) && !sel_ready &&
                       (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign expire_addr = txn_addr;

  // Stall counter and sticky timeout flag.
  always_ff @(posedge io_clk or posedge io_rst) begin
    if (io_rst) begin
      cnt         <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state == ST_IDLE && io_addr_strobe && hit)
        cnt <= '0;
      else if (state == ST_BUSY && !sel_ready)
        cnt <= cnt + 1'b1;
      if (err_clear)
        err_timeout <= 1'b0;
      if (expire)
        err_timeout <= 1'b1;
    end
  end

  // Address of the accepted transaction, reported if it later times out.
  always_ff @(posedge io_clk) begin
    if (state == ST_IDLE && io_addr_strobe && hit)
      txn_addr <= io_address;
  end
`else
  assign expire      = 1'b0;
  assign expire_addr = '0;
  assign err_timeout = 1'b0;
`endif

endmodule
